// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Vote positions are bit_cnt values within a 16-tick bit cell.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_e;

    localparam logic [3:0] VOTE_LO  = 4'd7;
    localparam logic [3:0] VOTE_MID = 4'd8;
    localparam logic [3:0] VOTE_HI  = 4'd9;
    localparam logic [3:0] BIT_LAST = 4'd15;

    localparam int DEFAULT_SYNC_STAGES = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX pin.
// Flops reset to 1 so an idle line never looks like a start bit.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic PCLK,
    input  logic aresetn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive engine: start detection, 3-sample majority vote, 7/8-bit
// framing with optional parity, and a single holding register for the wrapper.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       PCLK,
    input  logic       aresetn,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : gBadSyncStages
        $error("uart_rx_framer: SYNC_STAGES must be 2 or 3");
    end
    if (OVERSAMPLE != 16) begin : gBadOversample
        $error("uart_rx_framer: OVERSAMPLE is fixed at 16");
    end

    logic rxs;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .PCLK    (PCLK),
        .aresetn (aresetn),
        .d_i     (rx),
        .q_o     (rxs)
    );

    rxState_e   state_q,      state_d;
    logic [3:0] bitCnt_q,     bitCnt_d;
    logic [2:0] dataIdx_q,    dataIdx_d;
    logic       armed_q,      armed_d;
    logic       samp7_q,      samp7_d;
    logic       samp8_q,      samp8_d;
    logic [7:0] shReg_q,      shReg_d;
    logic       cfgBit8_q,    cfgBit8_d;
    logic       cfgParEn_q,   cfgParEn_d;
    logic       cfgOdd_q,     cfgOdd_d;
    logic       perr_q,       perr_d;
    logic [7:0] rxData_q,     rxData_d;
    logic       rxRdy_q,      rxRdy_d;
    logic       parityErr_q,  parityErr_d;
    logic       framingErr_q, framingErr_d;
    logic       overflow_q,   overflow_d;

    logic       vote;
    logic       voteTick;
    logic       lastTick;
    logic       complete;
    logic [7:0] frame;

    assign vote     = majority3(samp7_q, samp8_q, rxs);
    assign voteTick = baud_tick && (bitCnt_q == VOTE_HI);
    assign lastTick = baud_tick && (bitCnt_q == BIT_LAST);
    // In 7-bit mode the LSB-first shifter leaves the data in [7:1].
    assign frame    = cfgBit8_q ? shReg_q : {1'b0, shReg_q[7:1]};

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            bitCnt_q     <= '0;
            dataIdx_q    <= '0;
            armed_q      <= 1'b0;
            samp7_q      <= 1'b0;
            samp8_q      <= 1'b0;
            shReg_q      <= '0;
            cfgBit8_q    <= 1'b0;
            cfgParEn_q   <= 1'b0;
            cfgOdd_q     <= 1'b0;
            perr_q       <= 1'b0;
            rxData_q     <= '0;
            rxRdy_q      <= 1'b0;
            parityErr_q  <= 1'b0;
            framingErr_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitCnt_q     <= bitCnt_d;
            dataIdx_q    <= dataIdx_d;
            armed_q      <= armed_d;
            samp7_q      <= samp7_d;
            samp8_q      <= samp8_d;
            shReg_q      <= shReg_d;
            cfgBit8_q    <= cfgBit8_d;
            cfgParEn_q   <= cfgParEn_d;
            cfgOdd_q     <= cfgOdd_d;
            perr_q       <= perr_d;
            rxData_q     <= rxData_d;
            rxRdy_q      <= rxRdy_d;
            parityErr_q  <= parityErr_d;
            framingErr_q <= framingErr_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bitCnt_d     = bitCnt_q;
        dataIdx_d    = dataIdx_q;
        armed_d      = armed_q;
        samp7_d      = samp7_q;
        samp8_d      = samp8_q;
        shReg_d      = shReg_q;
        cfgBit8_d    = cfgBit8_q;
        cfgParEn_d   = cfgParEn_q;
        cfgOdd_d     = cfgOdd_q;
        perr_d       = perr_q;
        rxData_d     = rxData_q;
        rxRdy_d      = rxRdy_q;
        parityErr_d  = parityErr_q;
        framingErr_d = 1'b0;
        overflow_d   = overflow_q;
        complete     = 1'b0;

        if (baud_tick && (state_q != IDLE)) begin
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == VOTE_LO) begin
                samp7_d = rxs;
            end
            if (bitCnt_q == VOTE_MID) begin
                samp8_d = rxs;
            end
        end

        case (state_q)
            IDLE: begin
                // Arming on a high sample keeps a held-low break from retriggering.
                if (baud_tick) begin
                    if (armed_q && !rxs) begin
                        state_d  = START;
                        bitCnt_d = '0;
                        armed_d  = 1'b0;
                    end else if (rxs) begin
                        armed_d = 1'b1;
                    end
                end
            end

            START: begin
                if (voteTick) begin
                    if (vote) begin
                        state_d = IDLE;
                    end else begin
                        cfgBit8_d  = bit8;
                        cfgParEn_d = parity_en;
                        cfgOdd_d   = odd_n_even;
                        shReg_d    = '0;
                        perr_d     = 1'b0;
                    end
                end else if (lastTick) begin
                    state_d   = DATA;
                    dataIdx_d = '0;
                end
            end

            DATA: begin
                if (voteTick) begin
                    shReg_d = {vote, shReg_q[7:1]};
                end else if (lastTick) begin
                    if (dataIdx_q == (cfgBit8_q ? 3'd7 : 3'd6)) begin
                        state_d = cfgParEn_q ? PARITY : STOP;
                    end else begin
                        dataIdx_d = dataIdx_q + 3'd1;
                    end
                end
            end

            PARITY: begin
                if (voteTick) begin
                    perr_d = ((^frame) ^ vote) != cfgOdd_q;
                end else if (lastTick) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (voteTick) begin
                    state_d      = IDLE;
                    armed_d      = vote;
                    complete     = 1'b1;
                    framingErr_d = !vote;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            if (!rxRdy_q || rd_ack) begin
                rxData_d    = frame;
                rxRdy_d     = 1'b1;
                parityErr_d = perr_q & cfgParEn_q;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (rd_ack && rxRdy_q) begin
            rxRdy_d     = 1'b0;
            parityErr_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    assign rx_data     = rxData_q;
    assign rx_rdy      = rxRdy_q;
    assign parity_err  = parityErr_q;
    assign framing_err = framingErr_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Receive bit-level engine of the UART. Sits between the RX pin and the APB register wrapper that holds the status and receive-data registers.
- Synchronises RX and detects start bits using a 16x-oversampling tick from the baud generator.
- Majority-votes each bit, assembles 7/8-bit frames with optional parity, and presents one holding register plus status flags to the wrapper.
- All logic runs on PCLK; baud_tick is a clock-enable, not a clock.

Parameters:
SYNC_STAGES, 2, RX synchroniser flops (2..3)
OVERSAMPLE, 16, ticks per bit; fixed; vote ticks are 7/8/9

Ports:
PCLK  in  1  system clock
aresetn  in  1  reset, asynchronous, active-low
baud_tick  in  1  one-PCLK pulse at 16x baud rate
rx  in  1  serial input, asynchronous, idle high
bit8  in  1  1 = 8 data bits, 0 = 7
parity_en  in  1  parity bit present
odd_n_even  in  1  1 = odd parity, 0 = even
rd_ack  in  1  one-PCLK pulse: wrapper consumed rx_data
rx_data  out  8  received byte; bit7 = 0 in 7-bit mode
rx_rdy  out  1  holding register valid
parity_err  out  1  parity mismatch for the held frame
framing_err  out  1  one-PCLK pulse: stop bit sampled low
overflow  out  1  frame lost because holding register was full

Behaviour:
Reset:
- Synchroniser resets to 1; rx_data = 0x00; rx_rdy = parity_err = framing_err = overflow = 0; state IDLE; counters 0; armed = 0.
- Reset mid-frame discards the partial frame. No output glitches on deassertion.

Sampling:
- All state changes occur only on PCLK edges with baud_tick = 1, except rd_ack handling, which is evaluated every PCLK.
- rxs is the synchronised rx. bit_cnt is 4 bits and wraps 15 -> 0.
- Vote = majority of rxs captured at bit_cnt 7, 8, 9. The decision is taken at the bit_cnt = 9 tick.

FSM states:
- IDLE:
  - armed is set when rxs = 1 on a tick.
  - Tick with armed = 1 and rxs = 0 -> START, with bit_cnt = 0 and armed = 0.
  - After a break (continuous low), no frame starts until rx returns high.
- START:
  - At the vote tick: vote = 1 means false start -> IDLE.
  - Vote = 0 latches bit8, parity_en and odd_n_even into frame_cfg. Mid-frame configuration changes are ignored.
  - At the bit_cnt = 15 tick -> DATA, with data_idx = 0.
- DATA:
  - At the vote tick, the vote shifts in LSB-first into the shift register.
  - At the bit_cnt = 15 tick after the last bit (idx 6 or 7) -> PARITY if parity is enabled, else STOP.
- PARITY:
  - At the vote tick, compute perr = (XOR of data bits XOR vote) != odd_n_even.
  - Even parity expects the total XOR to be 0; odd parity expects 1.
  - At the bit_cnt = 15 tick -> STOP.
- STOP:
  - At the vote tick -> IDLE immediately (half stop bit, allows back-to-back frames), with armed = vote.
  - Frame completion happens on this same tick.

Frame completion (the STOP vote tick):
- If rx_rdy = 0, or rd_ack is asserted in the same cycle:
  - rx_data <= frame;
  - rx_rdy <= 1;
  - parity_err <= perr AND parity_en; overflow is left unchanged.
- Else (holding register full):
  - rx_data and parity_err are kept;
  - overflow <= 1 and the new frame is dropped.
- framing_err pulses high for exactly one PCLK if the stop vote = 0. The pulse occurs whether the frame is loaded or dropped. A frame with a framing error is still delivered.

rd_ack:
- With no completion in the same cycle: rx_rdy <= 0, parity_err <= 0, overflow <= 0.
- rd_ack while rx_rdy = 0 is ignored. rx_data is not cleared.

Latency:
- rx_rdy rises 1 PCLK after the STOP vote tick, i.e. 9.5 bit-times after the start-bit falling edge plus synchroniser delay (8N1, no parity).

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - VOTE_LO = 7, VOTE_MID = 8, VOTE_HI = 9, BIT_LAST = 15;
  - DEFAULT_SYNC_STAGES = 2.
- One sub-module, uart_rx_sync: parameterised synchroniser whose flops reset to 1.
- The majority vote and FSM stay in uart_rx_framer.

Test Plan:
- 8N1, bit8 = 1, parity_en = 0: send 0xA5 at 16 ticks/bit -> rx_data = 0xA5, rx_rdy = 1 one PCLK after the stop vote tick; parity_err = 0; no framing_err pulse.
- 7E1 (bit8 = 0, parity_en = 1, odd_n_even = 0): send 0x41 with parity bit 1 (wrong) -> rx_data = 0x41, parity_err = 1. Then rd_ack -> rx_rdy = 0, parity_err = 0.
- Stop bit driven low on 0x3C -> rx_data = 0x3C, rx_rdy = 1, framing_err high for exactly 1 PCLK. Hold rx low 3 frames -> no further frames until rx goes high.
- Glitch: rx low for 4 ticks, then high -> FSM returns to IDLE at the vote tick; rx_rdy stays 0.
- Overflow: receive 0x11, then 0x22 without rd_ack -> rx_data = 0x11, overflow = 1. Then rd_ack -> overflow = 0.
- rd_ack on the same cycle as completion of 0x55, with 0x11 held -> rx_data = 0x55, rx_rdy = 1, overflow = 0. Reset asserted mid-DATA -> all outputs 0 and the next clean frame is received correctly.
